// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module : lfsr_pkg
// Brief  : Shared types, default taps and next-state function for lfsr_rng.
// Rev    : 1.0  initial release
// ============================================================================
package lfsr_pkg;

    localparam int LFSR_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SEED = 2'd2
    } lfsr_state_e;

    // Maximal-length Fibonacci tap masks; bit i set means state[i] feeds the XOR.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_default_taps(input int width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            default: return '0;
        endcase
    endfunction

    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int                    width
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic                  fb;
        mask = {LFSR_MAX_W{1'b1}} >> (LFSR_MAX_W - width);
        fb   = ^(state & taps & mask);
        return ((state << 1) | {{(LFSR_MAX_W-1){1'b0}}, fb}) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_rng_if.sv
`default_nettype none
// ============================================================================
// Module : lfsr_rng_if
// Brief  : Seed/control inputs and valid/ready random-word stream of lfsr_rng.
// Rev    : 1.0  initial release
// ============================================================================
interface lfsr_rng_if #(
    parameter int WIDTH = 6
);
    logic             load;
    logic [WIDTH-1:0] seed;
    logic             shift_en;
    logic             seed_bit;
    logic             enable;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             wrap;
    logic             lockup;

    modport master (
        input  load, seed, shift_en, seed_bit, enable, out_ready,
        output out_valid, out, wrap, lockup
    );

    modport slave (
        output load, seed, shift_en, seed_bit, enable, out_ready,
        input  out_valid, out, wrap, lockup
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
// Module : lfsr_core
// Brief  : LFSR state register with load > shift > advance input mux.
// Rev    : 1.0  initial release
// ============================================================================
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 6,
    parameter logic [WIDTH-1:0] TAPS       = 6'b110000,
    parameter logic [WIDTH-1:0] RESET_SEED = 6'd1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_shift,
    input  wire logic             i_shift_bit,
    input  wire logic             i_adv,
    output logic      [WIDTH-1:0] o_state,
    output logic      [WIDTH-1:0] o_adv_val
);

    logic [WIDTH-1:0] r_state;

    assign o_adv_val = WIDTH'(lfsr_next(LFSR_MAX_W'(r_state), LFSR_MAX_W'(TAPS), WIDTH));
    assign o_state   = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RESET_SEED;
        end else if (i_load) begin
            r_state <= i_load_val;
        end else if (i_shift) begin
            r_state <= {r_state[WIDTH-2:0], i_shift_bit};
        end else if (i_adv) begin
            r_state <= o_adv_val;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lfsr_rng.sv
`default_nettype none
// ============================================================================
// Module : lfsr_rng
// Brief  : Fibonacci LFSR RNG with seeding, valid/ready output and wrap
//          detection. Define LFSR_LOCKUP_GUARD_EN to build the all-zero guard.
// Rev    : 1.0  initial release
// ============================================================================
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 6,
    parameter logic [WIDTH-1:0] TAPS       = 6'b110000,
    parameter logic [WIDTH-1:0] RESET_SEED = 6'd1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    lfsr_rng_if.master  bus
);

    lfsr_state_e      r_fsm;
    lfsr_state_e      w_fsm_next;
    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic [WIDTH-1:0] w_state;
    logic [WIDTH-1:0] w_adv;
    logic             w_hs;
    logic             w_seed_done;
    logic             w_sub_load;
    logic             w_sub_seed;
    logic             w_sub_adv;
    logic             w_core_load;
    logic [WIDTH-1:0] w_core_val;

    // A handshake only counts when neither seeding path claims the cycle.
    assign w_hs        = (r_fsm == ST_RUN) && bus.out_ready && !bus.load && !bus.shift_en;
    assign w_seed_done = (r_fsm == ST_SEED) && !bus.load && !bus.shift_en;

`ifdef LFSR_LOCKUP_GUARD_EN
    logic r_lockup;

    assign w_sub_load = bus.load && (bus.seed == '0);
    assign w_sub_seed = w_seed_done && (w_state == '0);
    assign w_sub_adv  = w_hs && (w_adv == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lockup <= 1'b0;
        end else begin
            r_lockup <= w_sub_load | w_sub_seed | w_sub_adv;
        end
    end

    assign bus.lockup = r_lockup;
`else
    assign w_sub_load = 1'b0;
    assign w_sub_seed = 1'b0;
    assign w_sub_adv  = 1'b0;
    assign bus.lockup = 1'b0;
`endif

    assign w_core_load = bus.load | w_sub_seed | w_sub_adv;
    assign w_core_val  = (w_sub_load | w_sub_seed | w_sub_adv) ? RESET_SEED : bus.seed;

    lfsr_core #(
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .RESET_SEED (RESET_SEED)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_core_load),
        .i_load_val  (w_core_val),
        .i_shift     (bus.shift_en),
        .i_shift_bit (bus.seed_bit),
        .i_adv       (w_hs),
        .o_state     (w_state),
        .o_adv_val   (w_adv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref  <= RESET_SEED;
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (bus.load) begin
                r_ref <= w_sub_load ? RESET_SEED : bus.seed;
                r_cnt <= '0;
            end else if (w_seed_done) begin
                r_ref <= w_sub_seed ? RESET_SEED : w_state;
                r_cnt <= '0;
            end else if (w_sub_adv) begin
                r_ref <= RESET_SEED;
                r_cnt <= '0;
            end else if (w_hs) begin
                if (w_adv == r_ref) begin
                    r_wrap <= 1'b1;
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        if (bus.load) begin
            w_fsm_next = ST_IDLE;
        end else if (bus.shift_en) begin
            w_fsm_next = ST_SEED;
        end else begin
            case (r_fsm)
                ST_IDLE: w_fsm_next = bus.enable ? ST_RUN : ST_IDLE;
                // Leave RUN only once the pending word has been taken.
                ST_RUN:  w_fsm_next = (!bus.enable && bus.out_ready) ? ST_IDLE : ST_RUN;
                ST_SEED: w_fsm_next = ST_IDLE;
                default: w_fsm_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.out_valid = (r_fsm == ST_RUN);
    end

    assign bus.out  = w_state;
    assign bus.wrap = r_wrap;

endmodule
`default_nettype wire

// File: doc/lfsr_rng.md
# lfsr_rng

Parametrised Fibonacci LFSR pseudo-random generator: the next generation of our 6-bit serial-seeded shifter. It adds configurable width and taps, parallel or serial seeding, a valid/ready output handshake, and period-wrap detection. It sits between a seed source (switches or a controller) and any consumer that pulls random words one at a time, such as display, dice or game logic.

## Interface
- `WIDTH`, default 6: LFSR and output width, minimum 3.
- `TAPS`, default 6'b110000: feedback mask. Bit i set means `state[i]` is in the XOR. The default is x^6+x^5+1, period 63.
- `RESET_SEED`, default 1: state value after reset. Must be nonzero.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `load`, input, 1: parallel seed load strobe.
- `seed`, input, WIDTH: parallel seed value.
- `shift_en`, input, 1: serial seeding active.
- `seed_bit`, input, 1: serial seed bit, shifted into bit 0.
- `enable`, input, 1: generator run request.
- `out_ready`, input, 1: consumer accepts `out` this cycle.
- `out_valid`, output, 1: `out` holds a fresh random word.
- `out`, output, WIDTH: current LFSR state.
- `wrap`, output, 1: one-cycle pulse when the state returns to the last seed.
- `lockup`, output, 1: one-cycle pulse when the all-zero state is replaced (guard builds only).

## Operation
- Next-state function: fb = ^(state & TAPS); advance = {state[WIDTH-2:0], fb}.
- FSM states:
  - IDLE: `out_valid`=0.
  - RUN: `out_valid`=1.
  - SEED: `out_valid`=0.
- Per-cycle priority, highest first: `load` > `shift_en` > advance.
- `load`, any state:
  - state <= `seed`; ref <= `seed`; cnt <= 0.
  - Next FSM state is IDLE.
  - Flushes any pending handshake. This is the only permitted way for `out_valid` to fall while `out_ready`=0.
- `shift_en` while `load`=0:
  - state <= {state[WIDTH-2:0], `seed_bit`}; FSM goes to SEED.
  - When `shift_en` falls: ref <= state, cnt <= 0, go to IDLE.
- IDLE to RUN when `enable`=1.
- RUN to IDLE when `enable`=0 and no word is pending, i.e. on a handshake or when the previous word was already taken. Otherwise stay in RUN holding `out` stable until `out_ready`.
- Advance happens only on a handshake (RUN and `out_ready`):
  - state <= advance; cnt <= cnt+1.
  - If advance == ref: `wrap`=1 and cnt <= 0.
- cnt is WIDTH bits and internal; it wraps modulo 2^WIDTH.
- All-zero state:
  - The LFSR is stuck at zero; behaviour depends on `LFSR_LOCKUP_GUARD_EN` (see Configuration).

## Timing
- Reset values:
  - state = `RESET_SEED`, ref = `RESET_SEED`, cnt = 0.
  - FSM = IDLE: `out_valid`=0, `wrap`=0, `lockup`=0.
- `out` is `state` driven directly from the register.
- `out_valid` is decoded from the FSM register, never combinationally from inputs.
- Latency:
  - `enable` rising edge to `out_valid`=1: 1 cycle.
  - Handshake to the next word on `out`: 1 cycle, so the sustained rate is one word per clock.
  - `load` to the new seed visible on `out`: 1 cycle, with `out_valid`=0 in that cycle.
- `wrap` and `lockup` are registered and assert in the same cycle as the state they describe.
- `load` and `shift_en` in the same cycle: `load` wins and the serial bit is dropped.
- Reset mid-operation, including mid-serial-seed: returns to the reset values immediately, independent of `clk`.

## Configuration
- `LFSR_LOCKUP_GUARD_EN` defined:
  - Any load, serial-seed completion or advance that would produce all-zero stores `RESET_SEED` instead.
  - ref is updated with the substituted value, and `lockup` pulses for 1 cycle.
- `LFSR_LOCKUP_GUARD_EN` undefined:
  - No guard logic is built and `lockup` is tied to 0.
  - An all-zero state is held forever.
  - `wrap` pulses on every handshake, since advance == ref == 0.

## Structure
- Shared package `lfsr_pkg`:
  - FSM state enum (IDLE, RUN, SEED).
  - Default tap constants per width 3..16, taken from a primitive-polynomial list.
  - A function that computes the next LFSR state from state and taps.
- One natural sub-module, `lfsr_core`:
  - State register plus next-state logic, with mux inputs for load, shift and advance.
  - The top level holds the FSM, ref/cnt, wrap detection and the lockup guard.

## Test plan
- Reset: assert `rst` mid-cycle → `out`=000001, `out_valid`=0 and `wrap`=0 asynchronously.
- Sequence from the default seed: `enable`=1 and `out_ready`=1 → `out` = 000001, 000010, 000100, 001000, 010000, 100001, 000011, one word per clock.
- Period: hold the handshake from seed 1 → `wrap` pulses exactly on accepted advance 63, and again at 126.
- Backpressure: `out_ready`=0 for 5 cycles in RUN, then `enable`=0 → `out` is stable and `out_valid` stays 1 until the handshake, then IDLE.
- Serial seed: `shift_en` for 6 cycles with `seed_bit` = 1,0,1,1,0,0 → `out`=101100 and `out_valid`=0. With `enable`=1 the next cycle gives `out_valid`=1. `load` asserted concurrently overrides it.
- Lockup: `load` with `seed`=0 → guard build gives `out`=000001 and a `lockup` pulse. Non-guard build gives `out`=000000 forever, with `wrap` on every handshake.
